// File: rtl/gbt_link_supervisor.sv
// rtl/gbt_link_supervisor.sv - multi-link GBT loopback supervisor
// Generates TX frames, checks RX frames and brings each link up with bounded bitslip retries.
module gbt_link_supervisor #(
  parameter int          NUM_LINKS     = 1,
  parameter int          DATA_W        = 84,
  parameter int          MODE          = 0,
  parameter logic [83:0] PATTERN       = 84'h000bebeac1dacdcfffff,
  parameter int          READY_TIMEOUT = 400,
  parameter int          LOCK_COUNT    = 16,
  parameter int          MAX_RETRY     = 7,
  parameter int          ERRCNT_W      = 16
) (
  input  logic                          clk_ix,
  input  logic                          rstn_ix,
  input  logic                          enable_i,
  input  logic                          clear_i,
  input  logic [NUM_LINKS-1:0]          link_ready_i,
  input  logic [NUM_LINKS-1:0]          rx_valid_i,
  input  logic [NUM_LINKS*DATA_W-1:0]   rx_data_i,
  output logic [NUM_LINKS*DATA_W-1:0]   tx_data_o,
  output logic [NUM_LINKS-1:0]          bitslip_rst_o,
  output logic [NUM_LINKS-1:0]          locked_o,
  output logic [NUM_LINKS-1:0]          failed_o,
  output logic [NUM_LINKS*ERRCNT_W-1:0] err_cnt_o,
  output logic [NUM_LINKS*8-1:0]        retry_cnt_o
);

  localparam logic [DATA_W-1:0]  PAT    = DATA_W'(PATTERN);
  localparam logic [DATA_W-33:0] PAT_UP = PAT[DATA_W-1:32];
  localparam int TW = $clog2(READY_TIMEOUT);
  localparam int GW = $clog2(LOCK_COUNT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_SLIP, S_LOCKING, S_LOCKED, S_FAILED
  } state_t;

  logic [31:0]       gen_cnt;
  logic [DATA_W-1:0] tx_q;

  // Counter is shared by all links; TX shows the value it held one cycle earlier.
  always_ff @(posedge clk_ix) begin
    if (!rstn_ix) begin
      gen_cnt <= '0;
      tx_q    <= (MODE == 1) ? {PAT_UP, 32'h0} : PAT;
    end else begin
      if (enable_i) gen_cnt <= gen_cnt + 32'd1;
      tx_q <= (MODE == 1) ? {PAT_UP, gen_cnt} : PAT;
    end
  end

  for (genvar k = 0; k < NUM_LINKS; k++) begin : g_link
    state_t              state, state_n;
    logic [TW-1:0]       timer;
    logic [7:0]          attempts;
    logic [GW-1:0]       good_cnt;
    logic [31:0]         prev;
    logic                have_prev;
    logic [ERRCNT_W-1:0] err_cnt;
    logic [7:0]          retry_cnt;
    logic                bitslip_q, locked_q, failed_q;
    logic [DATA_W-1:0]   rx;
    logic                checking, judged, frame_ok, frame_good, frame_bad;

    assign rx         = rx_data_i[k*DATA_W +: DATA_W];
    assign checking   = rx_valid_i[k] && (state == S_LOCKING || state == S_LOCKED);
    // In counting mode the first frame after entering LOCKING only seeds the reference.
    assign judged     = checking && !((MODE == 1) && !have_prev);
    assign frame_ok   = (MODE == 1) ? ((rx[DATA_W-1:32] == PAT_UP) && (rx[31:0] == prev + 32'd1))
                                    : (rx == PAT);
    assign frame_good = judged && frame_ok;
    assign frame_bad  = judged && !frame_ok;

    always_comb begin
      state_n = state;
      case (state)
        S_IDLE:    if (enable_i) state_n = S_WAIT;
        S_WAIT: begin
          if (link_ready_i[k]) state_n = S_LOCKING;
          else if (timer == TW'(READY_TIMEOUT - 1))
            state_n = (attempts < 8'(MAX_RETRY)) ? S_SLIP : S_FAILED;
        end
        S_SLIP:    state_n = S_WAIT;
        S_LOCKING: begin
          if (!link_ready_i[k]) state_n = S_WAIT;
          else if (frame_good && good_cnt == GW'(LOCK_COUNT - 1)) state_n = S_LOCKED;
        end
        S_LOCKED:  if (!link_ready_i[k]) state_n = S_WAIT;
        S_FAILED:  if (clear_i) state_n = S_IDLE;
        default:   state_n = S_IDLE;
      endcase
      if (!enable_i && state != S_FAILED) state_n = S_IDLE;
    end

    always_ff @(posedge clk_ix) begin
      if (!rstn_ix) begin
        state     <= S_IDLE;
        timer     <= '0;
        attempts  <= '0;
        good_cnt  <= '0;
        prev      <= '0;
        have_prev <= 1'b0;
        err_cnt   <= '0;
        retry_cnt <= '0;
        bitslip_q <= 1'b0;
        locked_q  <= 1'b0;
        failed_q  <= 1'b0;
      end else begin
        state     <= state_n;
        bitslip_q <= (state_n == S_SLIP);
        locked_q  <= (state_n == S_LOCKED);
        failed_q  <= (state_n == S_FAILED);
        timer     <= (state == S_WAIT) ? timer + TW'(1) : '0;

        if (state == S_IDLE || state == S_LOCKED) attempts <= '0;
        else if (state == S_SLIP)                 attempts <= attempts + 8'd1;

        if (state != S_LOCKING) good_cnt <= '0;
        else if (frame_good)    good_cnt <= good_cnt + GW'(1);
        else if (frame_bad)     good_cnt <= '0;

        if (state != S_LOCKING && state != S_LOCKED) have_prev <= 1'b0;
        else if (rx_valid_i[k])                      have_prev <= 1'b1;
        if (checking) prev <= rx[31:0];

        // Clear overrides any increment landing in the same cycle.
        if (clear_i) err_cnt <= '0;
        else if (state == S_LOCKED && enable_i && frame_bad && err_cnt != {ERRCNT_W{1'b1}})
          err_cnt <= err_cnt + ERRCNT_W'(1);

        if (clear_i) retry_cnt <= '0;
        else if (state == S_SLIP && enable_i && retry_cnt != 8'hFF)
          retry_cnt <= retry_cnt + 8'd1;
      end
    end

    assign tx_data_o[k*DATA_W +: DATA_W]     = tx_q;
    assign bitslip_rst_o[k]                  = bitslip_q;
    assign locked_o[k]                       = locked_q;
    assign failed_o[k]                       = failed_q;
    assign err_cnt_o[k*ERRCNT_W +: ERRCNT_W] = err_cnt;
    assign retry_cnt_o[k*8 +: 8]             = retry_cnt;
  end

endmodule

// File: tb/tb_gbt_link_supervisor.sv
// tb/tb_gbt_link_supervisor.sv - randomized bench for gbt_link_supervisor
// Drives a static-pattern and a counting-pattern instance against one behavioural model.
module tb_gbt_link_supervisor;

  localparam int NL = 4;
  localparam int DW = 40;
  localparam int RT = 12;
  localparam int LC = 4;
  localparam int MR = 3;
  localparam int EW = 4;
  localparam int ERRMAX = (1 << EW) - 1;
  localparam logic [83:0]   PATTERN = 84'h000bebeac1dacdcfffff;
  localparam logic [DW-1:0] PAT     = PATTERN[DW-1:0];
  localparam int NCYC = 6000;

  localparam int IDLE = 0, WAIT = 1, SLIP = 2, LOCKING = 3, LOCKED = 4, FAILED = 5;

  logic clk = 1'b0;
  logic rstn, en, clr;
  logic [NL-1:0] rdy, vld;
  logic [NL*DW-1:0] rx0, rx1, tx0, tx1;
  logic [NL-1:0] bs0, bs1, lk0, lk1, fl0, fl1;
  logic [NL*EW-1:0] ec0, ec1;
  logic [NL*8-1:0] rc0, rc1;

  always #5 clk = ~clk;

  gbt_link_supervisor #(.NUM_LINKS(NL), .DATA_W(DW), .MODE(0), .PATTERN(PATTERN),
    .READY_TIMEOUT(RT), .LOCK_COUNT(LC), .MAX_RETRY(MR), .ERRCNT_W(EW)) u_static (
    .clk_ix(clk), .rstn_ix(rstn), .enable_i(en), .clear_i(clr),
    .link_ready_i(rdy), .rx_valid_i(vld), .rx_data_i(rx0), .tx_data_o(tx0),
    .bitslip_rst_o(bs0), .locked_o(lk0), .failed_o(fl0), .err_cnt_o(ec0), .retry_cnt_o(rc0));

  gbt_link_supervisor #(.NUM_LINKS(NL), .DATA_W(DW), .MODE(1), .PATTERN(PATTERN),
    .READY_TIMEOUT(RT), .LOCK_COUNT(LC), .MAX_RETRY(MR), .ERRCNT_W(EW)) u_count (
    .clk_ix(clk), .rstn_ix(rstn), .enable_i(en), .clear_i(clr),
    .link_ready_i(rdy), .rx_valid_i(vld), .rx_data_i(rx1), .tx_data_o(tx1),
    .bitslip_rst_o(bs1), .locked_o(lk1), .failed_o(fl1), .err_cnt_o(ec1), .retry_cnt_o(rc1));

  int n_cmp = 0;
  int n_bad = 0;

  int ph[2][NL], tmr[2][NL], att[2][NL], good[2][NL], err[2][NL], rty[2][NL];
  bit have[2][NL];
  logic [31:0] prev[2][NL];
  logic [31:0] gen;
  logic [DW-1:0] mtx[2];
  logic [DW-1:0] rxf[2][NL];
  logic [31:0] rcnt[NL];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    gen = '0;
    mtx[0] = PAT;
    mtx[1] = {PAT[DW-1:32], 32'h0};
    for (int m = 0; m < 2; m++)
      for (int k = 0; k < NL; k++) begin
        ph[m][k] = IDLE; tmr[m][k] = 0; att[m][k] = 0; good[m][k] = 0;
        err[m][k] = 0; rty[m][k] = 0; have[m][k] = 0; prev[m][k] = '0;
      end
  endtask

  // One clock of the rules, applied to the inputs currently driven.
  task automatic model_step();
    int p, np;
    bit judged, ok;
    if (!rstn) begin
      model_reset();
      return;
    end
    mtx[1] = {PAT[DW-1:32], gen};
    if (en) gen = gen + 32'd1;
    for (int m = 0; m < 2; m++)
      for (int k = 0; k < NL; k++) begin
        p = ph[m][k];
        np = p;
        judged = 0;
        ok = 0;
        if (vld[k] && (p == LOCKING || p == LOCKED)) begin
          if (!(m == 1 && !have[m][k])) begin
            judged = 1;
            if (m == 0) ok = (rxf[m][k] == PAT);
            else ok = (rxf[m][k][DW-1:32] == PAT[DW-1:32]) && (rxf[m][k][31:0] == prev[m][k] + 32'd1);
          end
          prev[m][k] = rxf[m][k][31:0];
          have[m][k] = 1;
        end
        case (p)
          IDLE: if (en) begin np = WAIT; tmr[m][k] = 0; att[m][k] = 0; end
          WAIT: begin
            if (rdy[k]) begin np = LOCKING; good[m][k] = 0; have[m][k] = 0; end
            else if (tmr[m][k] == RT - 1) np = (att[m][k] < MR) ? SLIP : FAILED;
            else tmr[m][k]++;
          end
          SLIP: begin
            att[m][k]++;
            if (en && rty[m][k] < 255) rty[m][k]++;
            tmr[m][k] = 0;
            np = WAIT;
          end
          LOCKING: begin
            if (!rdy[k]) begin np = WAIT; tmr[m][k] = 0; end
            else if (judged) begin
              if (ok) begin
                good[m][k]++;
                if (good[m][k] == LC) np = LOCKED;
              end else good[m][k] = 0;
            end
          end
          LOCKED: begin
            att[m][k] = 0;
            if (judged && !ok && en && err[m][k] < ERRMAX) err[m][k]++;
            if (!rdy[k]) begin np = WAIT; tmr[m][k] = 0; end
          end
          default: if (clr) np = IDLE;
        endcase
        if (!en && p != FAILED) np = IDLE;
        if (clr) begin err[m][k] = 0; rty[m][k] = 0; end
        ph[m][k] = np;
      end
  endtask

  task automatic compare_all(input int cyc);
    for (int k = 0; k < NL; k++) begin
      check($sformatf("c%0d static tx%0d", cyc, k), 64'(tx0[k*DW +: DW]), 64'(mtx[0]));
      check($sformatf("c%0d count tx%0d", cyc, k), 64'(tx1[k*DW +: DW]), 64'(mtx[1]));
      for (int m = 0; m < 2; m++) begin
        check($sformatf("c%0d m%0d bitslip%0d", cyc, m, k), 64'(m == 0 ? bs0[k] : bs1[k]), 64'(ph[m][k] == SLIP));
        check($sformatf("c%0d m%0d locked%0d", cyc, m, k), 64'(m == 0 ? lk0[k] : lk1[k]), 64'(ph[m][k] == LOCKED));
        check($sformatf("c%0d m%0d failed%0d", cyc, m, k), 64'(m == 0 ? fl0[k] : fl1[k]), 64'(ph[m][k] == FAILED));
        check($sformatf("c%0d m%0d errcnt%0d", cyc, m, k),
              64'(m == 0 ? ec0[k*EW +: EW] : ec1[k*EW +: EW]), 64'(err[m][k]));
        check($sformatf("c%0d m%0d retrycnt%0d", cyc, m, k),
              64'(m == 0 ? rc0[k*8 +: 8] : rc1[k*8 +: 8]), 64'(rty[m][k]));
      end
    end
  endtask

  initial begin
    bit directed;
    rstn = 1'b0; en = 1'b0; clr = 1'b0; rdy = '0; vld = '0;
    rx0 = '0; rx1 = '0;
    for (int k = 0; k < NL; k++) begin
      rcnt[k] = $urandom;
      rxf[0][k] = PAT;
      rxf[1][k] = {PAT[DW-1:32], rcnt[k]};
    end
    model_reset();

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      if (cyc >= 2) compare_all(cyc);

      directed = (cyc >= 4000 && cyc < 4600);
      rstn = !(cyc < 2 || cyc == 3000 || $urandom_range(0, 1999) == 0);
      if (directed) en = 1'b1;
      else if (cyc == 4600) en = 1'b0;
      else if (en) en = ($urandom_range(0, 399) != 0);
      else en = ($urandom_range(0, 9) == 0);
      clr = !directed && ($urandom_range(0, 249) == 0);

      for (int k = 0; k < NL; k++) begin
        if (directed) rdy[k] = (k != 2);
        else if (rdy[k]) rdy[k] = ($urandom_range(0, 199) != 0);
        else rdy[k] = ($urandom_range(0, (k == 2) ? 299 : 24) == 0);
        vld[k] = ($urandom_range(0, 99) < 85);

        rxf[0][k] = PAT;
        if ($urandom_range(0, 29) == 0) rxf[0][k][$urandom_range(0, DW - 1)] ^= 1'b1;

        if (vld[k]) begin
          if (!directed && $urandom_range(0, 299) == 0) rcnt[k] = 32'hFFFFFFF0 + 32'($urandom_range(0, 8));
          else rcnt[k] = rcnt[k] + 32'd1;
          rxf[1][k] = {PAT[DW-1:32], rcnt[k]};
          if ($urandom_range(0, 29) == 0) rxf[1][k][$urandom_range(0, DW - 1)] ^= 1'b1;
        end
        rx0[k*DW +: DW] = rxf[0][k];
        rx1[k*DW +: DW] = rxf[1][k];
      end
      model_step();
    end
    @(negedge clk);
    compare_all(NCYC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
